// File: rtl/shift_pkg.sv
// Shared definitions for the two-stage shift/rotate pipeline.
//   WIDTH  : datapath width (only 16 is supported)
//   CNT_W  : shift-count width (fixed at 4, i.e. 0..15)
//   OP_*   : shift opcodes carried alongside each entry
package shift_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  typedef logic [WIDTH-1:0] data_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [1:0]       op_t;

  localparam op_t OP_ROL = 2'b00;
  localparam op_t OP_SLL = 2'b01;
  localparam op_t OP_ROR = 2'b10;
  localparam op_t OP_SRL = 2'b11;

endpackage

// File: rtl/shift_pipe_stage_if.sv
// Handshake/data bundle for shift_pipe_stage.
//   in_valid/in_ready   : issue-side handshake (ID/EX boundary)
//   in_op/in_data/in_cnt: opcode, operand and 4-bit shift amount
//   flush               : squash every in-flight entry
//   out_valid/out_ready : result-side handshake (EX/MEM writeback select)
//   out_data/out_op     : result and the opcode tag that travelled with it
// Modports: master = producer/consumer around the unit, slave = the unit.
interface shift_pipe_stage_if;
  import shift_pkg::*;

  logic  in_valid;
  logic  in_ready;
  op_t   in_op;
  data_t in_data;
  cnt_t  in_cnt;
  logic  flush;
  logic  out_valid;
  logic  out_ready;
  data_t out_data;
  op_t   out_op;

  modport master (
    output in_valid, in_op, in_data, in_cnt, flush, out_ready,
    input  in_ready, out_valid, out_data, out_op
  );

  modport slave (
    input  in_valid, in_op, in_data, in_cnt, flush, out_ready,
    output in_ready, out_valid, out_data, out_op
  );

endinterface

// File: rtl/shift_row.sv
// One row of the logarithmic shifter: shifts or rotates by DIST when en=1,
// otherwise passes the operand through.
//   in  : operand
//   op  : OP_ROL / OP_SLL / OP_ROR / OP_SRL
//   en  : this row's count bit
//   out : row result
module shift_row
  import shift_pkg::*;
#(
  parameter int DIST = 1
) (
  input  data_t in,
  input  op_t   op,
  input  logic  en,
  output data_t out
);

  always_comb begin
    // NOTE: out gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    out = in;
    if (en) begin
      case (op)
        OP_ROL:  out = {in[WIDTH-1-DIST:0], in[WIDTH-1:WIDTH-DIST]};
        OP_SLL:  out = in << DIST;
        OP_ROR:  out = {in[DIST-1:0], in[WIDTH-1:DIST]};
        default: out = in >> DIST;  // OP_SRL
      endcase
    end
  end

endmodule

// File: rtl/shift_pipe_stage.sv
// Two-stage pipelined 16-bit shift/rotate unit.
// Stage 1 applies count bits [1:0] (rows 1 and 2), stage 2 applies count
// bits [3:2] (rows 4 and 8); since every row uses the same op-selected
// function, the two stages compose into a single shift by the full count.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (beats flush and handshakes)
//   bus : shift_pipe_stage_if.slave (issue/result handshakes and flush)
module shift_pipe_stage
  import shift_pkg::*;
(
  input logic               clk,
  input logic               rst,
  shift_pipe_stage_if.slave bus
);

  logic       s1_valid;
  op_t        s1_op;
  logic [1:0] s1_cnt_hi;
  data_t      s1_data;

  logic  s2_valid;
  op_t   s2_op;
  data_t s2_data;

  logic  adv1;
  logic  adv2;
  data_t row1_out;
  data_t data1;
  data_t row4_out;
  data_t data2;

  // A stage may load when it is empty or its contents move on this edge.
  // in_ready therefore depends combinationally on out_ready; there is no
  // skid buffer to break that path.
  assign adv2         = !s2_valid || bus.out_ready;
  assign adv1         = !s1_valid || adv2;
  assign bus.in_ready = adv1;

  // Stage 1 rows: distances 1 and 2.
  shift_row #(.DIST(1)) u_row1 (
    .in (bus.in_data),
    .op (bus.in_op),
    .en (bus.in_cnt[0]),
    .out(row1_out)
  );

  shift_row #(.DIST(2)) u_row2 (
    .in (row1_out),
    .op (bus.in_op),
    .en (bus.in_cnt[1]),
    .out(data1)
  );

  // Stage 2 rows: distances 4 and 8, driven by the registered count bits.
  shift_row #(.DIST(4)) u_row4 (
    .in (s1_data),
    .op (s1_op),
    .en (s1_cnt_hi[0]),
    .out(row4_out)
  );

  shift_row #(.DIST(8)) u_row8 (
    .in (row4_out),
    .op (s1_op),
    .en (s1_cnt_hi[1]),
    .out(data2)
  );

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= OP_ROL;
      s1_cnt_hi <= 2'b00;
      s1_data   <= '0;
      s2_valid  <= 1'b0;
      s2_op     <= OP_ROL;
      s2_data   <= '0;
    end else begin
      if (adv1) begin
        s1_valid  <= bus.in_valid;
        s1_op     <= bus.in_op;
        s1_cnt_hi <= bus.in_cnt[3:2];
        s1_data   <= data1;
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        s2_op    <= s1_op;
        s2_data  <= data2;
      end
      // Flush overrides the valid updates above; data registers may load
      // but are never observed without a valid bit.
      if (bus.flush) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_op    = s2_op;

endmodule

// File: doc/shift_pipe_stage.md
Name: shift_pipe_stage

Overview:
- Two-stage pipelined 16-bit shift/rotate unit for the execute datapath of the 16-bit core.
- Accepts an operand, a 4-bit count and a shift opcode from the ID/EX boundary, and delivers the result to EX/MEM writeback selection.
- Performs the log-shifter rows across two register stages: count bits [1:0] in stage 1, count bits [3:2] in stage 2.
- Uses valid/ready backpressure and a pipeline flush.

Parameters:
- WIDTH, 16, data width; only 16 is supported, and the count width is fixed at 4.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand/count/op present this cycle
- in_ready  out  1  stage 1 can accept this cycle
- in_op  in  2  00 ROL, 01 SLL, 10 ROR, 11 SRL
- in_data  in  16  operand
- in_cnt  in  4  shift amount, 0..15
- flush  in  1  squash all in-flight entries
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  16  shifted/rotated result
- out_op  out  2  opcode carried alongside the result (debug/forwarding tag)

Behaviour:
- Reset: on rst at a clock edge, s1_valid=0 and s2_valid=0, so out_valid=0. out_data=0x0000 and out_op=00. All internal data registers are cleared to 0.
- Reset takes priority over flush and over any handshake. Reset mid-operation discards all entries, and no output appears for them.
- Transfer occurs on a clock edge when valid&&ready (both input and output sides).
- adv2 = !s2_valid || out_ready.
- adv1 = !s1_valid || adv2.
- in_ready = adv1. This is a combinational path from out_ready to in_ready and is intended; there is no skid buffer.
- Stage 1, loaded when adv1:
  - s1_valid <= in_valid.
  - Captures op, cnt[3:2], and data1, where data1 = in_data shifted by cnt[1:0] per op.
- Stage 2, loaded when adv2:
  - s2_valid <= s1_valid.
  - Captures op and data2, where data2 = data1 shifted by {cnt[3:2],2'b00} per op.
- When a stage does not advance, it holds all of its registers; out_data and out_op stay stable while out_valid && !out_ready.
- Latency: an input accepted at edge N produces out_valid=1 after edge N+1 (visible from edge N+1 until consumed). Throughput is one result per cycle when out_ready=1 continuously.
- Operation semantics (cnt=0 returns the operand unchanged for all ops):
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - ROL: bits leaving the MSB re-enter at the LSB.
  - ROR: bits leaving the LSB re-enter at the MSB.
- Each stage applies the same op-selected row function, so the composed result equals a single shift by the full cnt. The op field travels unchanged through both stages.
- Flush, when asserted at an edge without rst:
  - s1_valid <= 0 and s2_valid <= 0.
  - Any input presented in the same cycle is dropped even if in_ready=1.
  - A result presented with out_valid && out_ready in the flush cycle counts as consumed; the downstream owns that decision.
- Order is strictly FIFO; there is no reordering or bypass.
- X-safety: data registers load only on advance, and valid bits never go X after reset.

Decomposition:
- Shared package shift_pkg holds:
  - opcode localparams OP_ROL=2'b00, OP_SLL=2'b01, OP_ROR=2'b10, OP_SRL=2'b11;
  - WIDTH=16 and CNT_W=4.
- One natural sub-module, shift_row:
  - combinational, parameter DIST (1/2/4/8);
  - inputs: in[15:0], op[1:0], en;
  - output: out[15:0], shifted or rotated by DIST when en=1, else passthrough.
- Stage 1 instantiates shift_row with DIST=1 and 2; stage 2 with DIST=4 and 8.

Test Plan:
- SRL in_data=0x8001, cnt=1, out_ready=1 -> out_valid one cycle after acceptance, out_data=0x4000, out_op=11.
- ROL 0x8001 cnt=4 -> 0x0018; ROR 0x0001 cnt=1 -> 0x8000; SLL 0xFFFF cnt=15 -> 0x8000; any op with cnt=0 on 0xA5C3 -> 0xA5C3.
- Back-to-back issue of 0x0001 SLL cnt=0,1,2,3 with out_ready=1 -> results 0x0001, 0x0002, 0x0004, 0x0008 on consecutive cycles, with in_ready continuously 1.
- Backpressure:
  - Issue three ops, then drop out_ready for 4 cycles.
  - in_ready falls once both stages are full, and out_data stays stable.
  - On release, all three results appear in order with no loss or duplication.
- Flush with both stages full plus in_valid=1 in the same cycle -> out_valid=0 the next cycle, no flushed or dropped result ever appears, and the following issue flows with normal latency.
- Assert rst for one cycle with entries in flight and out_ready=0 -> out_valid=0, out_data=0x0000, in_ready=1 on the next cycle, and no stale results afterward.
